if_fetch_queue: RTL and testbench

- Consumer side of the IF-stage PC register.
- Reads the current word-address PC, issues instruction-memory requests, and generates the PC write enable (PCWrite) that advances the PC or loads a redirect.
- Buffers returned instructions with their PC in an in-order queue and presents them to ID through a valid/ready handshake.
- On a branch or exception redirect, discards queued and in-flight fetches.

---
 rtl/if_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// IF-stage fetch issue and in-order instruction queue toward ID, with redirect drop handling.
// Optional performance counters (perf_drop_o, perf_bubble_o) are enabled by defining IFQ_PERF_EN.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] pc_i,
  output logic        pc_write_o,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [29:0] id_pc_o
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_drop_o,
  output logic [31:0] perf_bubble_o
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [29:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_fill;
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_drop_cnt;

  logic [PW-1:0] w_alloc_cnt;
  logic [PW-1:0] w_outstanding;
  logic [PW-1:0] w_drop_next;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_fill_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_grant;
  logic          w_rsp_accept;
  logic          w_rsp_orphan;
  logic          w_pop;

  assign w_alloc_cnt   = r_wr - r_rd;
  assign w_outstanding = r_wr - r_fill;
  assign w_wr_idx      = r_wr[AW-1:0];
  assign w_fill_idx    = r_fill[AW-1:0];
  assign w_rd_idx      = r_rd[AW-1:0];
  assign w_full        = (r_wr[AW] != r_rd[AW]) && (w_wr_idx == w_rd_idx);

  // Outputs are gated by reset so they read 0 while reset is held, not just after the edge.
  assign imem_req_o  = reset && !flush_i && (r_drop_cnt == '0) && !w_full;
  assign imem_addr_o = pc_i;
  assign w_grant     = imem_req_o && imem_gnt_i;
  assign pc_write_o  = reset && (flush_i || w_grant);

  assign id_valid_o = (w_alloc_cnt != '0) && r_filled[w_rd_idx];
  assign id_instr_o = r_instr[w_rd_idx];
  assign id_pc_o    = r_pc[w_rd_idx];
  assign w_pop      = id_valid_o && id_ready_i && !flush_i;

  assign w_rsp_accept = imem_rvalid_i && !flush_i && (r_drop_cnt == '0) && (w_outstanding != '0);
  assign w_rsp_orphan = imem_rvalid_i && !flush_i && (r_drop_cnt == '0) && (w_outstanding == '0);

  // A flush-cycle response belongs to the old stream, so it is charged against the new drop count.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (flush_i) begin
      w_drop_next = r_drop_cnt + w_outstanding;
      if (imem_rvalid_i && (w_drop_next != '0)) begin
        w_drop_next = w_drop_next - ONE;
      end
    end else if (imem_rvalid_i && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr       <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_drop_cnt <= '0;
      r_filled   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr       <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_filled   <= '0;
      r_drop_cnt <= w_drop_next;
    end else begin
      r_drop_cnt <= w_drop_next;
      if (w_grant) begin
        r_pc[w_wr_idx]     <= pc_i;
        r_filled[w_wr_idx] <= 1'b0;
        r_wr               <= r_wr + ONE;
      end
      if (w_rsp_accept) begin
        r_instr[w_fill_idx]  <= imem_rdata_i;
        r_filled[w_fill_idx] <= 1'b1;
        r_fill               <= r_fill + ONE;
      end
      if (w_pop) begin
        r_filled[w_rd_idx] <= 1'b0;
        r_rd               <= r_rd + ONE;
      end
    end
  end

`ifdef IFQ_PERF_EN
  logic        w_rsp_discard;
  logic [31:0] r_perf_drop;
  logic [31:0] r_perf_bubble;

  assign w_rsp_discard = imem_rvalid_i && (flush_i || (r_drop_cnt != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_drop   <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_rsp_discard) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end
      if (!id_valid_o && id_ready_i) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign perf_drop_o   = r_perf_drop;
  assign perf_bubble_o = r_perf_bubble;
`endif

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset) !w_rsp_orphan);
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4); drives the imem side by hand.
module tb_if_fetch_queue;
  logic        clk;
  logic        reset;
  logic [29:0] pc_i;
  logic        pc_write_o;
  logic        imem_req_o;
  logic [29:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [29:0] id_pc_o;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_drop_o;
  logic [31:0] perf_bubble_o;
`endif

  int n_checks;
  int n_fail;
  logic [2:0] obs;
  assign obs = {imem_req_o, pc_write_o, id_valid_o};

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_i         (pc_i),
    .pc_write_o   (pc_write_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .flush_i      (flush_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o)
`ifdef IFQ_PERF_EN
    ,
    .perf_drop_o  (perf_drop_o),
    .perf_bubble_o(perf_bubble_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    flush_i       = 1'b0;
    id_ready_i    = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    pc_i       = 30'h0000BFF;
    imem_gnt_i = 1'b1;
    #2;
    n_checks++;
    if (obs !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", obs, 3'b000);
    end
    n_checks++;
    if ({id_instr_o, id_pc_o} !== 62'd0) begin
      n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", id_instr_o, id_pc_o);
    end
`ifdef IFQ_PERF_EN
    n_checks++;
    if ({perf_drop_o, perf_bubble_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_drop_o, perf_bubble_o);
    end
`endif
  endtask

  task automatic test_stream();
    apply_reset();
    pc_i = 30'h0000BFF; imem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b110 || imem_addr_o !== 30'h0000BFF) begin
      n_fail++; $display("FAIL stream_c0: got %b addr %h want 110 addr 0bff", obs, imem_addr_o);
    end
    next_cycle();
    pc_i = 30'h0000C00; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA000_0001;
    #1;
    n_checks++;
    if (obs !== 3'b110) begin
      n_fail++; $display("FAIL stream_c1: got %b want %b", obs, 3'b110);
    end
    next_cycle();
    pc_i = 30'h0000C01; imem_rdata_i = 32'hA000_0002; id_ready_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b111 || id_pc_o !== 30'h0000BFF || id_instr_o !== 32'hA000_0001) begin
      n_fail++; $display("FAIL stream_c2: got %b %h %h want 111 0bff a0000001", obs, id_pc_o, id_instr_o);
    end
    next_cycle();
    pc_i = 30'h0000C02; imem_gnt_i = 1'b0; imem_rdata_i = 32'hA000_0003;
    #1;
    n_checks++;
    if (obs !== 3'b101 || id_pc_o !== 30'h0000C00 || id_instr_o !== 32'hA000_0002) begin
      n_fail++; $display("FAIL stream_c3: got %b %h %h want 101 0c00 a0000002", obs, id_pc_o, id_instr_o);
    end
    next_cycle();
    imem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b101 || id_pc_o !== 30'h0000C01 || id_instr_o !== 32'hA000_0003) begin
      n_fail++; $display("FAIL stream_c4: got %b %h %h want 101 0c01 a0000003", obs, id_pc_o, id_instr_o);
    end
    next_cycle();
    #1;
    n_checks++;
    if (obs !== 3'b100) begin
      n_fail++; $display("FAIL stream_empty: got %b want %b", obs, 3'b100);
    end
  endtask

  task automatic test_full();
    int  grants;
    logic adv;
    apply_reset();
    pc_i = 30'h200; imem_gnt_i = 1'b1; grants = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      adv = imem_req_o && imem_gnt_i;
      if (adv) grants++;
      next_cycle();
      if (adv) pc_i = pc_i + 30'd1;
    end
    #1;
    n_checks++;
    if (grants !== 4) begin
      n_fail++; $display("FAIL full_grants: got %0d want 4", grants);
    end
    n_checks++;
    if (obs !== 3'b000) begin
      n_fail++; $display("FAIL full_stall: got %b want %b", obs, 3'b000);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hB000_0000;
    next_cycle();
    imem_rvalid_i = 1'b0; id_ready_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b001 || id_pc_o !== 30'h200) begin
      n_fail++; $display("FAIL full_pop_cycle: got %b %h want 001 200", obs, id_pc_o);
    end
    next_cycle();
    id_ready_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b110) begin
      n_fail++; $display("FAIL full_reissue: got %b want %b", obs, 3'b110);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    pc_i = 30'h050; imem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      pc_i = pc_i + 30'd1;
    end
    imem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b010) begin
      n_fail++; $display("FAIL flush_cycle: got %b want %b", obs, 3'b010);
    end
    next_cycle();
    flush_i = 1'b0; pc_i = 30'h100; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata_i = 32'hDEAD_0001 + 32'(i);
      #1;
      n_checks++;
      if (obs !== 3'b000) begin
        n_fail++; $display("FAIL flush_drop%0d: got %b want %b", i, obs, 3'b000);
      end
      next_cycle();
    end
    imem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b110 || imem_addr_o !== 30'h100) begin
      n_fail++; $display("FAIL flush_resume: got %b addr %h want 110 addr 100", obs, imem_addr_o);
    end
    next_cycle();
    imem_gnt_i = 1'b0; pc_i = 30'h101; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0100;
    #1;
    n_checks++;
    if (obs !== 3'b100) begin
      n_fail++; $display("FAIL flush_wait: got %b want %b", obs, 3'b100);
    end
    next_cycle();
    imem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b101 || id_pc_o !== 30'h100 || id_instr_o !== 32'hC0DE_0100) begin
      n_fail++; $display("FAIL flush_head: got %b %h %h want 101 100 c0de0100", obs, id_pc_o, id_instr_o);
    end
`ifdef IFQ_PERF_EN
    n_checks++;
    if (perf_drop_o !== 32'd3) begin
      n_fail++; $display("FAIL perf_drop: got %0d want 3", perf_drop_o);
    end
`endif
  endtask

  task automatic test_flush_rsp();
    apply_reset();
    pc_i = 30'h300; imem_gnt_i = 1'b1;
    next_cycle();
    pc_i = 30'h301;
    next_cycle();
    imem_gnt_i = 1'b0; flush_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hE000_0001;
    #1;
    n_checks++;
    if (obs !== 3'b010) begin
      n_fail++; $display("FAIL frsp_flush: got %b want %b", obs, 3'b010);
    end
    next_cycle();
    flush_i = 1'b0; pc_i = 30'h400; imem_gnt_i = 1'b1; imem_rdata_i = 32'hE000_0002;
    #1;
    n_checks++;
    if (obs !== 3'b000) begin
      n_fail++; $display("FAIL frsp_drop: got %b want %b", obs, 3'b000);
    end
    next_cycle();
    imem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b110 || imem_addr_o !== 30'h400) begin
      n_fail++; $display("FAIL frsp_resume: got %b addr %h want 110 addr 400", obs, imem_addr_o);
    end
    next_cycle();
    imem_gnt_i = 1'b0; pc_i = 30'h401; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hF000_0400;
    next_cycle();
    imem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b101 || id_pc_o !== 30'h400 || id_instr_o !== 32'hF000_0400) begin
      n_fail++; $display("FAIL frsp_head: got %b %h %h want 101 400 f0000400", obs, id_pc_o, id_instr_o);
    end
  endtask

  task automatic test_back_to_back();
    int grants;
    apply_reset();
    pc_i = 30'h010; imem_gnt_i = 1'b1;
    next_cycle();
    pc_i = 30'h011; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0010;
    next_cycle();
    pc_i = 30'h012; imem_rdata_i = 32'hBBBB_0011; id_ready_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b111 || id_pc_o !== 30'h010 || id_instr_o !== 32'hAAAA_0010) begin
      n_fail++; $display("FAIL b2b_triple: got %b %h %h want 111 010 aaaa0010", obs, id_pc_o, id_instr_o);
    end
    next_cycle();
    pc_i = 30'h013; imem_rvalid_i = 1'b0; id_ready_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b111 || id_pc_o !== 30'h011 || id_instr_o !== 32'hBBBB_0011) begin
      n_fail++; $display("FAIL b2b_order: got %b %h %h want 111 011 bbbb0011", obs, id_pc_o, id_instr_o);
    end
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req_o && imem_gnt_i) grants++;
      next_cycle();
      #1;
    end
    n_checks++;
    if (grants !== 2) begin
      n_fail++; $display("FAIL b2b_alloc: got %0d further grants want 2", grants);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    pc_i = 30'h020; imem_gnt_i = 1'b1;
    next_cycle();
    pc_i = 30'h021; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    next_cycle();
    imem_gnt_i = 1'b0; imem_rdata_i = 32'h2222_2222;
    next_cycle();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 3'b111 || id_pc_o !== 30'h020 || id_instr_o !== 32'h1111_1111) begin
      n_fail++; $display("FAIL arst_pre: got %b %h %h want 111 020 11111111", obs, id_pc_o, id_instr_o);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b000 || id_pc_o !== 30'h0 || id_instr_o !== 32'h0) begin
      n_fail++; $display("FAIL arst_now: got %b %h %h want 000 0 0", obs, id_pc_o, id_instr_o);
    end
    next_cycle();
    reset = 1'b1; imem_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 3'b100) begin
      n_fail++; $display("FAIL arst_release: got %b want %b", obs, 3'b100);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    pc_i     = '0;
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_flush_rsp();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
